// File: rtl/fwd_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// fwd_hazard_ctrl
//
// Hazard controller for the 5-stage RV32I pipeline. It keeps shadow copies
// of the register-use fields for the Execute, Memory and Writeback stages.
// From them it derives:
//   - the Execute-stage operand forwarding selects,
//   - the load-use stall, and
//   - the taken-branch flush controls.
// It also keeps two saturating event counters.
//
// Ports
//   clk, reset         core clock; asynchronous active-high reset
//   Rs1D, Rs2D, RdD    register indices of the instruction in Decode
//   RegWriteD, LoadD   Decode instruction writes the RF / is a load
//   PCSrcE             branch/jump taken, resolved in Execute
//   ForwardAE/BE       operand selects: 00 RF, 01 Writeback, 10 Memory ALU
//   StallF, StallD     hold PC / IF-ID register
//   FlushD, FlushE     clear IF-ID / ID-EX register
//   stall_cnt          load-use stall cycles (saturating)
//   flush_cnt          taken-branch flush cycles (saturating)
// ---------------------------------------------------------------------------
module fwd_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] RdD,
    input  logic              RegWriteD,
    input  logic              LoadD,
    input  logic              PCSrcE,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic              FlushE,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Shadow pipeline state
    logic [REG_AW-1:0] r_rs1_e;
    logic [REG_AW-1:0] r_rs2_e;
    logic [REG_AW-1:0] r_rd_e;
    logic              r_reg_write_e;
    logic              r_load_e;
    logic [REG_AW-1:0] r_rd_m;
    logic              r_reg_write_m;
    logic [REG_AW-1:0] r_rd_w;
    logic              r_reg_write_w;

    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic              w_lw_stall;
    logic              w_flush_e;

    // Memory stage wins over Writeback because it holds the younger value.
    // x0 is hard-wired to zero, so it is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rd_m,
        input logic              we_m,
        input logic [REG_AW-1:0] rd_w,
        input logic              we_w
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (we_m && (rd_m != '0) && (rd_m == rs)) begin
            sel = 2'b10;
        end else if (we_w && (rd_w != '0) && (rd_w == rs)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    // -----------------------------------------------------------------------
    // Hazard detection and forwarding (combinational)
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every output gets a default before any branch, so no path
        // leaves a value unassigned and no latch is inferred.
        w_lw_stall = 1'b0;
        w_flush_e  = 1'b0;
        ForwardAE  = 2'b00;
        ForwardBE  = 2'b00;
        StallF     = 1'b0;
        StallD     = 1'b0;
        FlushD     = 1'b0;
        FlushE     = 1'b0;

        // Outputs are held at zero for the whole reset window, including
        // when a taken branch is presented at the same time.
        if (!reset) begin
            w_lw_stall = r_load_e && (r_rd_e != '0) &&
                         ((r_rd_e == Rs1D) || (r_rd_e == Rs2D));
            w_flush_e  = w_lw_stall || PCSrcE;

            ForwardAE  = fwd_sel(r_rs1_e, r_rd_m, r_reg_write_m,
                                 r_rd_w, r_reg_write_w);
            ForwardBE  = fwd_sel(r_rs2_e, r_rd_m, r_reg_write_m,
                                 r_rd_w, r_reg_write_w);

            // A flush and a stall on IF/ID may both be raised; the pipeline
            // gives the flush precedence.
            StallF     = w_lw_stall;
            StallD     = w_lw_stall;
            FlushD     = PCSrcE;
            FlushE     = w_flush_e;
        end
    end

    // -----------------------------------------------------------------------
    // Shadow pipeline registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state is updated with non-blocking assignments so each
        // stage samples the value its predecessor held before the edge.
        if (reset) begin
            r_rs1_e       <= '0;
            r_rs2_e       <= '0;
            r_rd_e        <= '0;
            r_reg_write_e <= 1'b0;
            r_load_e      <= 1'b0;
            r_rd_m        <= '0;
            r_reg_write_m <= 1'b0;
            r_rd_w        <= '0;
            r_reg_write_w <= 1'b0;
        end else begin
            if (w_flush_e) begin
                // Bubble: a bubble neither writes nor loads, so it can never
                // be a forwarding source or re-trigger the load-use stall.
                r_rs1_e       <= '0;
                r_rs2_e       <= '0;
                r_rd_e        <= '0;
                r_reg_write_e <= 1'b0;
                r_load_e      <= 1'b0;
            end else begin
                r_rs1_e       <= Rs1D;
                r_rs2_e       <= Rs2D;
                r_rd_e        <= RdD;
                r_reg_write_e <= RegWriteD;
                r_load_e      <= LoadD;
            end
            r_rd_m        <= r_rd_e;
            r_reg_write_m <= r_reg_write_e;
            r_rd_w        <= r_rd_m;
            r_reg_write_w <= r_reg_write_m;
        end
    end

    // -----------------------------------------------------------------------
    // Saturating event counters
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_lw_stall && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
            if (PCSrcE && (r_flush_cnt != CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
